// File: rtl/noc_pkg.sv
// Shared definitions for the flit-tree merge blocks: flit geometry,
// the flit type and the two-state round-robin arbiter encoding.
package noc_pkg;

    localparam int FLIT_W   = 9;
    localparam int ADDR_MSB = 8;
    localparam int ADDR_LSB = 5;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef enum logic {
        PRIO0 = 1'b0,
        PRIO1 = 1'b1
    } arb_state_t;

endpackage

// File: rtl/noc_hold_slot.sv
// One-entry valid/ready holding buffer. A held flit leaves when the
// consumer pulses drain; a new flit may enter in that same cycle.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_data    upstream flit offer
//   in_ready            upstream may transfer (!full || drain)
//   drain               consumer takes the held flit this edge
//   full/data           registered occupancy flag and held flit
module noc_hold_slot
    import noc_pkg::*;
#(
    parameter int DW = FLIT_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    input  logic          drain,
    output logic          full,
    output logic [DW-1:0] data
);

    logic          full_q;
    logic          full_d;
    logic [DW-1:0] data_q;
    logic [DW-1:0] data_d;

    // drain frees the slot early so a refill lands on the same edge
    assign in_ready = !full_q || drain;
    assign full     = full_q;
    assign data     = data_q;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (drain) begin
            full_d = 1'b0;
        end
        if (in_valid && in_ready) begin
            full_d = 1'b1;
            data_d = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/merge2_arb.sv
// Two-to-one round-robin flit merge with a registered parent output.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   in0_valid/in0_data/in0_ready  child 0 channel
//   in1_valid/in1_data/in1_ready  child 1 channel
//   out_valid/out_data/out_src    registered parent flit and its source
//   out_ready                     parent accepts
//   stat_clr, stat_cnt0/1         per-child forward counters, present
//                                 only when MERGE_STATS_EN is defined
module merge2_arb
    import noc_pkg::*;
#(
    parameter int DW     = FLIT_W,
    parameter int ADDR_W = ADDR_MSB - ADDR_LSB + 1
`ifdef MERGE_STATS_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in0_valid,
    input  logic [DW-1:0] in0_data,
    output logic          in0_ready,
    input  logic          in1_valid,
    input  logic [DW-1:0] in1_data,
    output logic          in1_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_src,
    input  logic          out_ready
`ifdef MERGE_STATS_EN
    ,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] stat_cnt0,
    output logic [CNT_W-1:0] stat_cnt1
`endif
);

    localparam int PAY_W = DW - ADDR_W;

    logic          full0;
    logic          full1;
    logic [DW-1:0] data0;
    logic [DW-1:0] data1;
    logic          grant0;
    logic          grant1;
    logic          load;
    logic [DW-1:0] sel_data;

    arb_state_t    state_q;
    arb_state_t    state_d;
    logic          out_valid_q;
    logic          out_valid_d;
    logic [DW-1:0] out_data_q;
    logic [DW-1:0] out_data_d;
    logic          out_src_q;
    logic          out_src_d;

    noc_hold_slot #(
        .DW (DW)
    ) u_slot0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in0_valid),
        .in_data  (in0_data),
        .in_ready (in0_ready),
        .drain    (grant0),
        .full     (full0),
        .data     (data0)
    );

    noc_hold_slot #(
        .DW (DW)
    ) u_slot1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in1_valid),
        .in_data  (in1_data),
        .in_ready (in1_ready),
        .drain    (grant1),
        .full     (full1),
        .data     (data1)
    );

    // Grants use only registered state, so in_valid never reaches
    // out_valid within one cycle.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        load   = (full0 || full1) && (!out_valid_q || out_ready);
        if (load) begin
            if (full0 && full1) begin
                grant0 = (state_q == PRIO0);
                grant1 = (state_q == PRIO1);
            end else if (full0) begin
                grant0 = 1'b1;
            end else begin
                grant1 = 1'b1;
            end
        end
    end

    // Winner hands priority to the other child.
    always_comb begin
        state_d = state_q;
        if (grant0) begin
            state_d = PRIO1;
        end else if (grant1) begin
            state_d = PRIO0;
        end
    end

    assign sel_data = grant1 ? data1 : data0;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = {sel_data[DW-1:PAY_W], sel_data[PAY_W-1:0]};
            out_src_d   = grant1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PRIO0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

`ifdef MERGE_STATS_EN
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt0_d;
    logic [CNT_W-1:0] cnt1_q;
    logic [CNT_W-1:0] cnt1_d;

    // Clear wins over a same-cycle grant; counts stick at all-ones.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (stat_clr) begin
            cnt0_d = '0;
            cnt1_d = '0;
        end else begin
            if (grant0 && !(&cnt0_q)) begin
                cnt0_d = cnt0_q + 1'b1;
            end
            if (grant1 && !(&cnt1_q)) begin
                cnt1_d = cnt1_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign stat_cnt0 = cnt0_q;
    assign stat_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_merge2_arb.sv
// Scoreboard bench for merge2_arb: directed contention, latency,
// backpressure and async-reset cases, then randomized traffic.
module tb_merge2_arb;
    import noc_pkg::*;

    typedef struct packed {
        logic  src;
        flit_t d;
    } ent_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    logic  v0 = 1'b0, v1 = 1'b0, ordy = 1'b0;
    flit_t d0 = '0, d1 = '0;
    logic  rdy0, rdy1, ov, osrc;
    flit_t od;
`ifdef MERGE_STATS_EN
    logic        sclr = 1'b0;
    logic [15:0] sc0, sc1;
`endif

    int checks = 0;
    int passed = 0;

    // reference model state
    flit_t slot0[$], slot1[$];
    flit_t send0[$], send1[$];
    ent_t  exp_q[$], log_q[$];
    bit    mv = 0, msrc = 0, mprio = 0;
    flit_t md = '0;
    int    cnt0 = 0, cnt1 = 0;
    bit    gaps = 0, rnd_ordy = 0;

    always #5 clk = ~clk;

    merge2_arb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_valid (v0),
        .in0_data  (d0),
        .in0_ready (rdy0),
        .in1_valid (v1),
        .in1_data  (d1),
        .in1_ready (rdy1),
        .out_valid (ov),
        .out_data  (od),
        .out_src   (osrc),
        .out_ready (ordy)
`ifdef MERGE_STATS_EN
        ,
        .stat_clr  (sclr),
        .stat_cnt0 (sc0),
        .stat_cnt1 (sc1)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    // Round-robin choice among occupied slots for a free output.
    function automatic void mgrant(input bit r, output bit g0, output bit g1);
        bit f0 = slot0.size() > 0;
        bit f1 = slot1.size() > 0;
        g0 = 0;
        g1 = 0;
        if ((f0 || f1) && (!mv || r)) begin
            if (f0 && f1) begin
                g0 = !mprio;
                g1 = mprio;
            end else begin
                g0 = f0;
                g1 = !f0;
            end
        end
    endfunction

    task automatic drive_inputs();
        if (!v0 && send0.size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
            v0 = 1;
            d0 = send0[0];
        end
        if (!v1 && send1.size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
            v1 = 1;
            d1 = send1[0];
        end
    endtask

    task automatic cycle();
        bit g0, g1, a0, a1;
        ent_t e;
        @(posedge clk);
        mgrant(ordy, g0, g1);
        a0 = v0 && (slot0.size() == 0 || g0);
        a1 = v1 && (slot1.size() == 0 || g1);
        if (g0 || g1) begin
            e.src = g1;
            e.d = g1 ? slot1[0] : slot0[0];
            mv = 1;
            md = e.d;
            msrc = g1;
            mprio = g0;
            exp_q.push_back(e);
        end else if (mv && ordy) begin
            mv = 0;
        end
`ifdef MERGE_STATS_EN
        if (sclr) begin
            cnt0 = 0;
            cnt1 = 0;
        end else begin
            if (g0 && cnt0 < 65535) cnt0++;
            if (g1 && cnt1 < 65535) cnt1++;
        end
`endif
        if (g0) void'(slot0.pop_front());
        if (g1) void'(slot1.pop_front());
        if (a0) slot0.push_back(d0);
        if (a1) slot1.push_back(d1);
        #1;
        if (a0) begin
            void'(send0.pop_front());
            v0 = 0;
        end
        if (a1) begin
            void'(send1.pop_front());
            v1 = 0;
        end
        drive_inputs();
        if (rnd_ordy) ordy = $urandom_range(3) != 0;
`ifdef MERGE_STATS_EN
        sclr = rnd_ordy && ($urandom_range(31) == 0);
`endif
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while ((send0.size() + send1.size() + slot0.size() + slot1.size() > 0
                || mv) && n < maxc) begin
            cycle();
            n++;
        end
        if (n >= maxc) begin
            checks++;
            $display("FAIL drain_timeout cycles=%0d limit=%0d", n, maxc);
        end
    endtask

    // monitor: compare DUT against model and pop scoreboard on handshakes
    always @(negedge clk) begin
        bit g0, g1;
        ent_t e;
        if (rst_n) begin
            mgrant(ordy, g0, g1);
            chk("out_valid", ov, mv);
            if (mv) begin
                chk("out_data", od, md);
                chk("out_src", osrc, msrc);
            end
            chk("in0_ready", rdy0, slot0.size() == 0 || g0);
            chk("in1_ready", rdy1, slot1.size() == 0 || g1);
`ifdef MERGE_STATS_EN
            chk("stat_cnt0", sc0, cnt0);
            chk("stat_cnt1", sc1, cnt1);
`endif
            if (ov && ordy) begin
                if (exp_q.size() == 0) begin
                    chk("sb_nonempty", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_data", od, e.d);
                    chk("sb_src", osrc, e.src);
                    log_q.push_back('{osrc, od});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        flit_t c_exp[6];
        bit    s_exp[6];
        int    n0, n1;
        c_exp = '{9'h010, 9'h110, 9'h011, 9'h111, 9'h012, 9'h112};
        s_exp = '{0, 1, 0, 1, 0, 1};

        // reset values
        #2;
        chk("rst_out_valid", ov, 0);
        chk("rst_out_data", od, 0);
        chk("rst_out_src", osrc, 0);
        chk("rst_in0_ready", rdy0, 1);
        chk("rst_in1_ready", rdy1, 1);
        @(negedge clk);
        #2 rst_n = 1;

        // contention: strict alternation starting at child 0
        ordy = 1;
        for (int i = 0; i < 3; i++) begin
            send0.push_back(flit_t'(9'h010 + i));
            send1.push_back(flit_t'(9'h110 + i));
        end
        log_q.delete();
        drive_inputs();
        drain(40);
        chk("cont_count", log_q.size(), 6);
        for (int i = 0; i < 6 && i < log_q.size(); i++) begin
            chk("cont_data", log_q[i].d, c_exp[i]);
            chk("cont_src", log_q[i].src, s_exp[i]);
        end

        // single input latency
        send0.push_back(9'h1A3);
        drive_inputs();
        cycle();
        #1;
        chk("single_no_early", ov, 0);
        chk("single_in0_ready", rdy0, 1);
        cycle();
        #1;
        chk("single_valid", ov, 1);
        chk("single_data", od, 9'h1A3);
        chk("single_src", osrc, 0);
        drain(20);

        // backpressure: both stall, then drain all six
        ordy = 0;
        for (int i = 0; i < 3; i++) begin
            send0.push_back(flit_t'(9'h020 + i));
            send1.push_back(flit_t'(9'h120 + i));
        end
        drive_inputs();
        repeat (5) cycle();
        #1;
        chk("bp_in0_stall", rdy0, 0);
        chk("bp_in1_stall", rdy1, 0);
        log_q.delete();
        ordy = 1;
        drain(40);
        n0 = 0;
        n1 = 0;
        foreach (log_q[i]) begin
            if (log_q[i].src) n1++;
            else n0++;
        end
        chk("bp_count0", n0, 3);
        chk("bp_count1", n1, 3);

        // async reset with both slots full, priority left at child 1
        ordy = 0;
        send0.push_back(9'h0AA);
        drive_inputs();
        repeat (3) cycle();
        send0.push_back(9'h0AB);
        send1.push_back(9'h1BB);
        drive_inputs();
        repeat (3) cycle();
        #3;
        rst_n = 0;
        v0 = 0;
        v1 = 0;
        slot0.delete();
        slot1.delete();
        send0.delete();
        send1.delete();
        exp_q.delete();
        mv = 0;
        mprio = 0;
        cnt0 = 0;
        cnt1 = 0;
        #1;
        chk("arst_out_valid", ov, 0);
        chk("arst_in0_ready", rdy0, 1);
        chk("arst_in1_ready", rdy1, 1);
        @(negedge clk);
        #2 rst_n = 1;
        send0.push_back(9'h0C0);
        send1.push_back(9'h1C0);
        drive_inputs();
        ordy = 1;
        log_q.delete();
        drain(20);
        chk("arst_count", log_q.size(), 2);
        if (log_q.size() > 0) begin
            chk("arst_first_src", log_q[0].src, 0);
            chk("arst_first_data", log_q[0].d, 9'h0C0);
        end

        // randomized traffic
        gaps = 1;
        rnd_ordy = 1;
        for (int i = 0; i < 1500; i++) begin
            if (send0.size() < 2 && $urandom_range(1) == 1)
                send0.push_back(flit_t'($urandom));
            if (send1.size() < 2 && $urandom_range(1) == 1)
                send1.push_back(flit_t'($urandom));
            cycle();
        end
        gaps = 0;
        rnd_ordy = 0;
        ordy = 1;
`ifdef MERGE_STATS_EN
        sclr = 0;
`endif
        drive_inputs();
        drain(200);
        cycle();
        chk("sb_empty_end", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
